reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised 2-read/1-write register file for the CPU datapath: DATA_W x 2**ADDR_W entries.
//  Adds same-cycle write-to-read bypass, an optional hard-wired zero register, and a
//  zero-extended immediate override on read port 2.
//  Integrated scoreboard: a busy bit per register, set at issue and cleared at write-back.
//  The decode stage reads the operands and stall from this block; write-back drives the write port.
// PARAMETERS
//  DATA_W    16  register width in bits
//  ADDR_W    4   address width; DEPTH = 2**ADDR_W registers
//  IMM_W     4   immediate width on imm_val (IMM_W <= DATA_W)
//  ZERO_REG  0   1: register 0 always reads 0, writes to it are dropped, it is never marked busy
// PORTS
//  clk         in   1          clock; all state updates on posedge
//  reset       in   1          synchronous, active-high
//  wr_en       in   1          write-back enable
//  wr_addr     in   ADDR_W     write-back register
//  wr_data     in   DATA_W     write-back data
//  rd_addr1    in   ADDR_W     read port 1 address
//  rd_addr2    in   ADDR_W     read port 2 address
//  imm_sel     in   1          1: rd_data2 = zero-extended imm_val
//  imm_val     in   IMM_W      immediate operand
//  issue_en    in   1          instruction issued that will write issue_addr
//  issue_addr  in   ADDR_W     destination register of the issued instruction
//  rd_data1    out  DATA_W     read data, port 1
//  rd_data2    out  DATA_W     read data, port 2 (or immediate)
//  stall       out  1          operand hazard: a needed source is busy and not bypassed
//  busy_cnt    out  ADDR_W+1   number of registers currently marked busy
// BEHAVIOUR
//  Reset (reset=1 at posedge): all registers <= 0, all busy bits <= 0, busy_cnt <= 0.
//   While reset=1, rd_data1 = rd_data2 = 0 and stall = 0, forced combinationally.
//   Reset overrides any write or issue in the same cycle.
//  Write: at posedge, if wr_en, reg[wr_addr] <= wr_data.
//   If ZERO_REG=1 and wr_addr==0, the write is dropped.
//  Read: combinational.
//   rdN = (wr_en && wr_addr==rd_addrN && !(ZERO_REG && rd_addrN==0)) ? wr_data : reg[rd_addrN].
//   ZERO_REG=1 and rd_addrN==0 -> 0.
//   imm_sel=1 -> rd_data2 = {(DATA_W-IMM_W)'b0, imm_val}; rd_addr2 is ignored for data and stall.
//  Busy effective: eff_busy(a) = busy[a] && !(wr_en && wr_addr==a).
//   An in-flight write-back clears the hazard in the same cycle, via the bypass.
//  stall = eff_busy(rd_addr1) | (eff_busy(rd_addr2) & ~imm_sel); combinational, 0 latency.
//  Scoreboard update at posedge, per address a:
//   - issue_en && issue_addr==a  -> busy[a] <= 1 (issue wins over a same-cycle write to a)
//   - else wr_en && wr_addr==a   -> busy[a] <= 0
//   - ZERO_REG=1 -> busy[0] is held at 0
//  Issue to an already-busy register: bit stays 1 (single outstanding write tracked).
//   Write to a non-busy register: data written, no scoreboard change.
//  busy_cnt: registered, always equals popcount(busy) after each edge.
//   Maintained incrementally:
//   - +1 on set of a clear bit
//   - -1 on clear of a set bit
//   - net 0 when one bit sets and another clears in the same cycle
//   Range 0..DEPTH, so it never wraps.
//  Latency: write visible via bypass in the same cycle, via the array from the next cycle.
// TESTING
//  1 Reset: hold reset 2 cycles with wr_en=1 -> all reads 0, busy_cnt=0, no register written.
//  2 Bypass: wr_en=1, wr_addr=3, wr_data=16'hBEEF, rd_addr1=3 -> rd_data1=BEEF same cycle;
//    next cycle wr_en=0 -> still BEEF.
//  3 Scoreboard: issue r5 -> next cycle rd_addr1=5 gives stall=1, busy_cnt=1;
//    write-back r5=16'h0042 -> stall=0 that cycle, rd_data1=0042; busy_cnt=0 after the edge.
//  4 Simultaneous: r7 busy; same cycle issue r7 + write r7 -> busy[7] stays 1, busy_cnt=1;
//    issue r2 + write r7 -> busy_cnt stays 1.
//  5 Immediate: r9 busy, rd_addr2=9, imm_sel=1, imm_val=4'hA, rd_addr1 idle
//    -> rd_data2=16'h000A, stall=0.
//  6 ZERO_REG=1: write 16'h1234 to r0, issue r0 -> rd_data1(r0)=0, stall=0, busy_cnt=0.

Source files
------------

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// 2-read / 1-write register file (DATA_W x 2**ADDR_W) with a scoreboard that
// tracks registers holding an outstanding write.
//   - Same-cycle write-to-read bypass on both read ports.
//   - Optional hard-wired zero register (ZERO_REG=1).
//   - Read port 2 can be replaced by a zero-extended immediate.
//   - Busy bit per register: set at issue, cleared at write-back.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   wr_en/wr_addr/wr_data   write-back port
//   rd_addr1, rd_addr2      read addresses (combinational reads)
//   imm_sel, imm_val        immediate override for read port 2
//   issue_en, issue_addr    destination of a newly issued instruction
//   rd_data1, rd_data2      read data (bypassed, zero-register aware)
//   stall                   a needed source is busy and not bypassed
//   busy_cnt                number of registers currently marked busy
// ---------------------------------------------------------------------------
module reg_file_sb #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int IMM_W    = 4,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              imm_sel,
    input  logic [IMM_W-1:0]  imm_val,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              stall,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam bit HAS_ZERO = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

    logic wr_ok;     // write actually lands in the array
    logic cnt_inc;   // a clear busy bit is being set
    logic cnt_dec;   // a set busy bit is being cleared

    // ---------------- next-state logic ----------------
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        regs_d     = regs_q;
        busy_d     = busy_q;
        busy_cnt_d = busy_cnt_q;

        wr_ok = wr_en && !(HAS_ZERO && wr_addr == '0);
        if (wr_ok) begin
            regs_d[wr_addr] = wr_data;
        end

        // Write-back clears first so a same-cycle issue to the same register wins.
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (issue_en) begin
            busy_d[issue_addr] = 1'b1;
        end
        if (HAS_ZERO) begin
            busy_d[0] = 1'b0;
        end

        // Incremental count: only real 0->1 and 1->0 transitions move it.
        cnt_inc = issue_en && !busy_q[issue_addr] && !(HAS_ZERO && issue_addr == '0);
        cnt_dec = wr_en && busy_q[wr_addr] && !(issue_en && issue_addr == wr_addr);
        case ({cnt_inc, cnt_dec})
            2'b10:   busy_cnt_d = busy_cnt_q + 1'b1;
            2'b01:   busy_cnt_d = busy_cnt_q - 1'b1;
            default: busy_cnt_d = busy_cnt_q;
        endcase
    end

    // ---------------- state registers ----------------
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the array is reset because architectural registers must read 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // ---------------- read ports and hazard ----------------
    logic [DATA_W-1:0] rd_raw1, rd_raw2;
    logic              eff_busy1, eff_busy2;

    always_comb begin
        rd_raw1 = regs_q[rd_addr1];
        if (HAS_ZERO && rd_addr1 == '0) begin
            rd_raw1 = '0;
        end else if (wr_en && wr_addr == rd_addr1) begin
            rd_raw1 = wr_data;
        end

        rd_raw2 = regs_q[rd_addr2];
        if (HAS_ZERO && rd_addr2 == '0) begin
            rd_raw2 = '0;
        end else if (wr_en && wr_addr == rd_addr2) begin
            rd_raw2 = wr_data;
        end

        // An in-flight write-back resolves the hazard through the bypass.
        eff_busy1 = busy_q[rd_addr1] && !(wr_en && wr_addr == rd_addr1);
        eff_busy2 = busy_q[rd_addr2] && !(wr_en && wr_addr == rd_addr2);

        if (reset) begin
            rd_data1 = '0;
            rd_data2 = '0;
            stall    = 1'b0;
        end else begin
            rd_data1 = rd_raw1;
            rd_data2 = imm_sel ? DATA_W'(imm_val) : rd_raw2;
            stall    = eff_busy1 || (eff_busy2 && !imm_sel);
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// ---------------------------------------------------------------------------
// tb_reg_file_sb
// Two instances share one stimulus stream: dut0 (ZERO_REG=0) and dut1
// (ZERO_REG=1). A behavioural model (plain arrays of register values and busy
// flags) predicts every output each cycle; directed sections add literal
// expectations that pin the model itself, then a randomized run follows.
// ---------------------------------------------------------------------------
module tb_reg_file_sb;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int IMM_W  = 4;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] rd_addr1, rd_addr2;
    logic              imm_sel;
    logic [IMM_W-1:0]  imm_val;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;

    logic [DATA_W-1:0] rd1_z0, rd2_z0, rd1_z1, rd2_z1;
    logic              stall_z0, stall_z1;
    logic [ADDR_W:0]   cnt_z0, cnt_z1;

    int checks = 0;
    int errors = 0;

    // Model state, indexed [zero_reg][address].
    logic [DATA_W-1:0] m_mem  [2][DEPTH];
    bit                m_busy [2][DEPTH];

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_W(IMM_W), .ZERO_REG(0)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .imm_sel(imm_sel), .imm_val(imm_val),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .rd_data1(rd1_z0), .rd_data2(rd2_z0), .stall(stall_z0), .busy_cnt(cnt_z0)
    );

    reg_file_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_W(IMM_W), .ZERO_REG(1)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .imm_sel(imm_sel), .imm_val(imm_val),
        .issue_en(issue_en), .issue_addr(issue_addr),
        .rd_data1(rd1_z1), .rd_data2(rd2_z1), .stall(stall_z1), .busy_cnt(cnt_z1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [DATA_W-1:0] exp_read(input int z, input logic [ADDR_W-1:0] a);
        if (reset) return '0;
        if (z == 1 && a == 0) return '0;
        if (wr_en && wr_addr == a) return wr_data;
        return m_mem[z][a];
    endfunction

    function automatic bit exp_hazard(input int z, input logic [ADDR_W-1:0] a);
        return m_busy[z][a] && !(wr_en && wr_addr == a);
    endfunction

    function automatic int popcount(input int z);
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_busy[z][i]);
        return n;
    endfunction

    // Apply the effect of a clock edge with the current inputs.
    task automatic model_edge();
        for (int z = 0; z < 2; z++) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[z][i]  = '0;
                    m_busy[z][i] = 1'b0;
                end
            end else begin
                if (wr_en && !(z == 1 && wr_addr == 0)) m_mem[z][wr_addr] = wr_data;
                if (wr_en) m_busy[z][wr_addr] = 1'b0;
                if (issue_en) m_busy[z][issue_addr] = 1'b1;
                if (z == 1) m_busy[z][0] = 1'b0;
            end
        end
    endtask

    // Compare both DUTs against the model; called once every cycle.
    task automatic compare_all();
        for (int z = 0; z < 2; z++) begin
            logic [DATA_W-1:0] a1, a2, e2;
            logic              as, es;
            logic [ADDR_W:0]   ac;
            a1 = (z == 1) ? rd1_z1 : rd1_z0;
            a2 = (z == 1) ? rd2_z1 : rd2_z0;
            as = (z == 1) ? stall_z1 : stall_z0;
            ac = (z == 1) ? cnt_z1 : cnt_z0;
            e2 = reset ? '0 : (imm_sel ? {{(DATA_W-IMM_W){1'b0}}, imm_val} : exp_read(z, rd_addr2));
            es = !reset && (exp_hazard(z, rd_addr1) || (exp_hazard(z, rd_addr2) && !imm_sel));
            check($sformatf("z%0d rd_data1", z), 32'(a1), 32'(exp_read(z, rd_addr1)));
            check($sformatf("z%0d rd_data2", z), 32'(a2), 32'(e2));
            check($sformatf("z%0d stall", z), 32'(as), 32'(es));
            check($sformatf("z%0d busy_cnt", z), 32'(ac), 32'(popcount(z)));
        end
    endtask

    task automatic settle();
        @(negedge clk);
        compare_all();
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        wr_en = 0; issue_en = 0; imm_sel = 0; reset = 0;
    endtask

    initial begin
        reset = 1; wr_en = 1; wr_addr = 3; wr_data = 16'hFFFF;
        rd_addr1 = 3; rd_addr2 = 5; imm_sel = 0; imm_val = 0;
        issue_en = 1; issue_addr = 5;

        // 1: reset held two cycles while write/issue are asserted.
        tick();
        settle();
        check("lit reset rd_data1", 32'(rd1_z0), 32'h0);
        check("lit reset stall", 32'(stall_z0), 32'h0);
        check("lit reset busy_cnt", 32'(cnt_z0), 32'h0);
        tick();
        idle();
        settle();
        check("lit no write during reset", 32'(rd1_z0), 32'h0);
        check("lit busy_cnt after reset", 32'(cnt_z0), 32'h0);
        tick();

        // 2: bypass then array read.
        wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF; rd_addr1 = 3;
        settle();
        check("lit bypass same cycle", 32'(rd1_z0), 32'hBEEF);
        tick();
        wr_en = 0;
        settle();
        check("lit array next cycle", 32'(rd1_z0), 32'hBEEF);
        tick();

        // 3: scoreboard set / clear through write-back.
        issue_en = 1; issue_addr = 5;
        settle(); tick();
        issue_en = 0; rd_addr1 = 5;
        settle();
        check("lit stall on busy r5", 32'(stall_z0), 32'h1);
        check("lit busy_cnt one", 32'(cnt_z0), 32'h1);
        tick();
        wr_en = 1; wr_addr = 5; wr_data = 16'h0042;
        settle();
        check("lit writeback clears stall", 32'(stall_z0), 32'h0);
        check("lit writeback bypass", 32'(rd1_z0), 32'h0042);
        tick();
        wr_en = 0;
        settle();
        check("lit busy_cnt back to zero", 32'(cnt_z0), 32'h0);
        tick();

        // 4: simultaneous issue and write-back.
        issue_en = 1; issue_addr = 7;
        settle(); tick();
        wr_en = 1; wr_addr = 7; wr_data = 16'h0077;
        settle(); tick();
        idle(); rd_addr1 = 7;
        settle();
        check("lit issue wins stall", 32'(stall_z0), 32'h1);
        check("lit issue wins busy_cnt", 32'(cnt_z0), 32'h1);
        tick();
        issue_en = 1; issue_addr = 2; wr_en = 1; wr_addr = 7; wr_data = 16'h0707;
        settle(); tick();
        idle(); rd_addr1 = 2; rd_addr2 = 7;
        settle();
        check("lit swap busy_cnt", 32'(cnt_z0), 32'h1);
        check("lit r2 now busy", 32'(stall_z0), 32'h1);
        tick();
        wr_en = 1; wr_addr = 2; wr_data = 16'h0222;
        settle(); tick();
        idle();

        // 5: immediate override hides a busy source on port 2.
        issue_en = 1; issue_addr = 9;
        settle(); tick();
        issue_en = 0; rd_addr1 = 0; rd_addr2 = 9; imm_sel = 1; imm_val = 4'hA;
        settle();
        check("lit imm data", 32'(rd2_z0), 32'h000A);
        check("lit imm no stall", 32'(stall_z0), 32'h0);
        tick();
        imm_sel = 0;
        settle();
        check("lit port2 busy stalls", 32'(stall_z0), 32'h1);
        tick();
        wr_en = 1; wr_addr = 9; wr_data = 16'h0999;
        settle(); tick();
        idle();

        // 6: zero register (dut1) versus plain register 0 (dut0).
        wr_en = 1; wr_addr = 0; wr_data = 16'h1234; issue_en = 1; issue_addr = 0; rd_addr1 = 0;
        settle();
        check("lit z1 r0 bypass blocked", 32'(rd1_z1), 32'h0);
        tick();
        idle();
        settle();
        check("lit z1 r0 reads zero", 32'(rd1_z1), 32'h0);
        check("lit z1 r0 no stall", 32'(stall_z1), 32'h0);
        check("lit z1 busy_cnt zero", 32'(cnt_z1), 32'h0);
        check("lit z0 r0 written", 32'(rd1_z0), 32'h1234);
        check("lit z0 r0 busy", 32'(stall_z0), 32'h1);
        tick();

        // Randomized traffic, checked every cycle against the model.
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 99) == 0);
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_addr    = ADDR_W'($urandom_range(0, DEPTH - 1));
            wr_data    = DATA_W'($urandom);
            issue_en   = ($urandom_range(0, 9) < 4);
            issue_addr = ADDR_W'($urandom_range(0, DEPTH - 1));
            rd_addr1   = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
            rd_addr2   = ($urandom_range(0, 3) == 0) ? wr_addr : ADDR_W'($urandom_range(0, DEPTH - 1));
            imm_sel    = ($urandom_range(0, 3) == 0);
            imm_val    = IMM_W'($urandom);
            settle();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
